audio_sample_shaper: RTL and testbench
======================================

# audio_sample_shaper

Sample-conditioning stage between the sine BRAM read port and the PWM modulator in the audio path. It buffers offset-binary samples in a small FIFO and applies a per-sample volume attenuation and a click-free mute/unmute gain ramp. It presents a new value to the PWM input only at PWM period boundaries, so each period carries exactly one sample.

## Interface
- DW, 11, sample width (offset-binary, midscale M = 2^(DW-1) = 1024)
- DEPTH, 4, FIFO entries (power of two)
- GW, 6, gain fraction bits; full-scale gain GMAX = 2^GW = 64
- CLK100MHZ  in  1  system clock, 100 MHz; all state on rising edge
- CPU_RESETN  in  1  reset, asynchronous, active-low; one clock, no other clock domains
- s_valid  in  1  upstream sample valid
- s_data  in  DW  upstream sample, offset-binary
- s_ready  out  1  FIFO can accept; equals !full (registered count, not a function of same-cycle pop)
- period_start  in  1  one-cycle pulse from PWM at start of each PWM period
- vol  in  3  attenuation, arithmetic right shift 0..7 of the signed sample
- mute  in  1  level request: 1 ramps gain to 0, 0 ramps gain to GMAX
- pwm_sample  out  DW  registered sample to PWM input
- underrun  out  1  one-cycle pulse: period_start arrived with FIFO empty
- muted  out  1  registered, high when gain == 0

## Operation
- Push: s_valid && s_ready stores s_data at tail. Data is never dropped while s_ready is high.
- Pop: on period_start with FIFO non-empty, the head is consumed and pwm_sample is loaded with the processed head.
- Simultaneous push and pop: both occur; count unchanged.
- Full with period_start: pop only. s_ready rises the next cycle.
- Empty with period_start (even if a push occurs that cycle): no bypass.
  - pwm_sample holds its value.
  - underrun pulses.
  - The pushed word is stored.
- Processing (signed arithmetic):
  - x = head − M (DW+1 signed).
  - xa = x >>> vol.
  - p = xa × g, where g is the unsigned gain 0..64 (signed product, ≥ DW+8 bits).
  - y = p >>> GW (floor).
  - pwm_sample = y + M.
  - Range is provably 0..2^DW−1; no saturation logic is needed.
- The gain used is g before this period's update. vol is sampled at the pop.
- Gain ramp FSM, evaluated on every period_start regardless of FIFO state:
  - MUTED (g=0): mute=0 → RAMP_UP with g=1.
  - RAMP_UP: mute=1 → RAMP_DOWN (g−1). Otherwise g+1; reaching 64 → FULL.
  - FULL (g=64): mute=1 → RAMP_DOWN with g=63.
  - RAMP_DOWN: mute=0 → RAMP_UP (g+1). Otherwise g−1; reaching 0 → MUTED.
  - Between period_start pulses, g and state are frozen. mute is only sampled on period_start.
- muted = (g == 0), registered alongside g.

## Timing
- Reset values, applied asynchronously while CPU_RESETN is low:
  - FIFO empty, s_ready=1.
  - pwm_sample=1024.
  - underrun=0.
  - g=0, state MUTED, muted=1.
- Reset mid-operation flushes the FIFO and discards the ramp position. Power-up therefore always fades in.
- Latency:
  - period_start high in cycle N → pwm_sample, g, muted and underrun update at the edge ending cycle N, visible in N+1.
  - A pushed word is poppable from the cycle after its push.
- underrun is high for exactly one cycle per empty period_start. Back-to-back pulses are possible.
- Full ramp takes 64 period_start pulses in either direction. A reversal mid-ramp takes effect on the same pulse.
- Pointers wrap modulo DEPTH; count spans 0..DEPTH.
- Single-cycle datapath, an 11×7 multiply, must close at 100 MHz.

## Test plan
- Reset: assert CPU_RESETN=0 mid-stream → pwm_sample=1024, muted=1, s_ready=1, underrun=0 immediately. After release, the FIFO is empty.
- Fade-in:
  - Setup: mute=0, vol=0, feed 2047 each period.
  - Pop 1 → 1024; pop 2 → 1039; pop 65 → 2047.
  - muted falls after the first period_start.
- FIFO full: offer 5 words with no period_start → 4 accepted, s_ready low after the 4th. Then period_start with s_valid high → pop only, s_ready=1 next cycle, count 3.
- Underrun: with the FIFO empty and g=64, pulse period_start twice → pwm_sample unchanged, two single-cycle underrun pulses. A push in the same cycle is stored and popped at the next period_start.
- Volume: with g=64 and vol=3, samples 0 and 2047 → pwm_sample 896 then 1151. With vol=7, sample 0 → 1016.
- Mute: from FULL with sample 2047 streaming, set mute=1 → output decays over 64 periods to 1024 and muted asserts. Clearing mute at g=32 → g increments on the next period_start.

Source files
------------

// File: rtl/audio_sample_shaper_if.sv
// rtl/audio_sample_shaper_if.sv - sample stream, period strobe, controls and PWM-side outputs of the shaper
//
// Purpose: bundles every non-clock, non-reset signal of audio_sample_shaper.
// Ports (as seen by the slave, i.e. the shaper itself):
//   s_valid, s_data[DW]  in   upstream offset-binary sample stream
//   s_ready              out  FIFO can accept a word
//   period_start         in   one-cycle pulse at the start of each PWM period
//   vol[3]               in   attenuation shift 0..7
//   mute                 in   gain ramp direction request
//   pwm_sample[DW]       out  registered sample for the PWM
//   underrun             out  period_start seen with the FIFO empty
//   muted                out  gain is zero
interface audio_sample_shaper_if #(
    parameter int DW = 11
) ();
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          period_start;
    logic [2:0]    vol;
    logic          mute;
    logic [DW-1:0] pwm_sample;
    logic          underrun;
    logic          muted;

    modport master (
        output s_valid, s_data, period_start, vol, mute,
        input  s_ready, pwm_sample, underrun, muted
    );

    modport slave (
        input  s_valid, s_data, period_start, vol, mute,
        output s_ready, pwm_sample, underrun, muted
    );
endinterface

// File: rtl/audio_sample_shaper.sv
// rtl/audio_sample_shaper.sv - sample FIFO with volume shift and click-free mute ramp feeding the PWM
//
// Purpose: buffers offset-binary samples, and on each PWM period boundary pops
// one sample, attenuates it by an arithmetic shift, scales it by a ramping gain
// and presents it to the PWM.
// Ports:
//   CLK100MHZ   in   system clock, all state on the rising edge
//   CPU_RESETN  in   asynchronous active-low reset
//   bus         slave modport of audio_sample_shaper_if (stream in, controls, PWM outputs)
module audio_sample_shaper #(
    parameter int DW    = 11,
    parameter int DEPTH = 4,
    parameter int GW    = 6
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESETN,
    audio_sample_shaper_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Product width: (DW+1)-bit signed sample times (GW+2)-bit signed gain.
    localparam int PW = DW + GW + 3;

    localparam logic [GW:0]          GMAX = {1'b1, {GW{1'b0}}};
    localparam logic [GW:0]          GONE = {{GW{1'b0}}, 1'b1};
    localparam logic signed [DW:0]   MID  = {2'b01, {(DW-1){1'b0}}};
    localparam logic signed [PW-1:0] YMID = {{(PW-DW-1){1'b0}}, MID};
    localparam logic [DW-1:0]        MIDQ = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        FULL      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // s_ready depends only on the registered count, so a same-cycle pop
    // of a full FIFO does not open the door until the next cycle.
    assign bus.s_ready = !full;
    assign push = bus.s_valid && !full;
    assign pop  = bus.period_start && !empty;

    always_ff @(posedge CLK100MHZ) begin
        if (push) begin
            mem[wr_ptr] <= bus.s_data;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // ------------------------------------------------------- gain ramp FSM
    state_t      state_q;
    state_t      state_d;
    logic [GW:0] gain_q;
    logic [GW:0] gain_d;
    logic        muted_q;
    logic        muted_d;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= MUTED;
            gain_q  <= '0;
            muted_q <= 1'b1;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            muted_q <= muted_d;
        end
    end

    // A reversal mid-ramp steps the gain in the new direction on the same
    // pulse; the end states are re-entered when a step lands on 0 or GMAX.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (bus.period_start) begin
            case (state_q)
                MUTED: begin
                    if (!bus.mute) begin
                        state_d = RAMP_UP;
                        gain_d  = GONE;
                    end
                end
                RAMP_UP: begin
                    if (bus.mute) begin
                        gain_d  = gain_q - GONE;
                        state_d = (gain_d == '0) ? MUTED : RAMP_DOWN;
                    end else begin
                        gain_d  = gain_q + GONE;
                        state_d = (gain_d == GMAX) ? FULL : RAMP_UP;
                    end
                end
                FULL: begin
                    if (bus.mute) begin
                        state_d = RAMP_DOWN;
                        gain_d  = GMAX - GONE;
                    end
                end
                RAMP_DOWN: begin
                    if (!bus.mute) begin
                        gain_d  = gain_q + GONE;
                        state_d = (gain_d == GMAX) ? FULL : RAMP_UP;
                    end else begin
                        gain_d  = gain_q - GONE;
                        state_d = (gain_d == '0) ? MUTED : RAMP_DOWN;
                    end
                end
                default: begin
                    state_d = MUTED;
                    gain_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        muted_d = (gain_d == '0);
    end

    assign bus.muted = muted_q;

    // ------------------------------------------------------------ datapath
    // Uses the gain before this period's ramp step.
    logic [DW-1:0]        head;
    logic signed [DW:0]   x;
    logic signed [DW:0]   xa;
    logic signed [PW-1:0] xa_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] y;
    logic [DW-1:0]        pwm_d;

    assign head   = mem[rd_ptr];
    assign x      = $signed({1'b0, head}) - MID;
    assign xa     = x >>> bus.vol;
    assign xa_ext = {{(PW-DW-1){xa[DW]}}, xa};
    assign g_ext  = {{(PW-GW-1){1'b0}}, gain_q};
    assign prod   = xa_ext * g_ext;
    assign y      = prod >>> GW;
    // |y| <= 2^(DW-1), so re-adding midscale always fits in DW bits.
    assign pwm_d  = DW'(y + YMID);

    logic [DW-1:0] pwm_q;
    logic          underrun_q;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pwm_q      <= MIDQ;
            underrun_q <= 1'b0;
        end else begin
            if (pop) begin
                pwm_q <= pwm_d;
            end
            underrun_q <= bus.period_start && empty;
        end
    end

    assign bus.pwm_sample = pwm_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_audio_sample_shaper.sv
// tb/tb_audio_sample_shaper.sv - self-checking bench for audio_sample_shaper against a queue-based model
module tb_audio_sample_shaper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    audio_sample_shaper_if #(.DW(11)) bus ();

    audio_sample_shaper #(.DW(11), .DEPTH(4), .GW(6)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .bus        (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: FIFO contents, current gain, expected registered outputs.
    int q[$];
    int g;
    int m_pwm;
    int m_und;

    function automatic int shape(int h, int v, int gg);
        int x;
        x = (h - 1024) >>> v;
        return ((x * gg) >>> 6) + 1024;
    endfunction

    task automatic model_reset();
        q.delete();
        g     = 0;
        m_pwm = 1024;
        m_und = 0;
    endtask

    task automatic model_clock();
        bit ps;
        bit push;
        int h;
        ps    = bus.period_start;
        push  = bus.s_valid && (q.size() < 4);
        m_und = (ps && q.size() == 0) ? 1 : 0;
        if (ps && q.size() > 0) begin
            h     = q.pop_front();
            m_pwm = shape(h, int'(bus.vol), g);
        end
        if (push) q.push_back(int'(bus.s_data));
        if (ps) g = bus.mute ? ((g > 0) ? g - 1 : 0) : ((g < 64) ? g + 1 : 64);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("s_ready",    32'(bus.s_ready),    (q.size() < 4) ? 32'd1 : 32'd0);
        chk("pwm_sample", 32'(bus.pwm_sample), 32'(m_pwm));
        chk("underrun",   32'(bus.underrun),   32'(m_und));
        chk("muted",      32'(bus.muted),      (g == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_clock();
        else       model_reset();
        #1;
        check_all();
        #1;
    endtask

    task automatic drive(bit sv, int sd, bit ps);
        bus.s_valid      = sv;
        bus.s_data       = 11'(sd);
        bus.period_start = ps;
    endtask

    task automatic period(int sd);
        drive(1'b1, sd, 1'b0);
        step();
        drive(1'b0, 0, 1'b1);
        step();
        drive(1'b0, 0, 1'b0);
    endtask

    initial begin
        model_reset();
        drive(1'b0, 0, 1'b0);
        bus.vol  = 3'd0;
        bus.mute = 1'b0;
        step();
        step();
        chk("rst_pwm",   32'(bus.pwm_sample), 32'd1024);
        chk("rst_muted", 32'(bus.muted),      32'd1);
        rst_n = 1'b1;
        step();

        // Fade-in with full-scale input
        for (int p = 1; p <= 65; p++) begin
            period(2047);
            if (p == 1) begin
                chk("fade_pop1",    32'(bus.pwm_sample), 32'd1024);
                chk("fade_unmuted", 32'(bus.muted),      32'd0);
            end
            if (p == 2)  chk("fade_pop2",  32'(bus.pwm_sample), 32'd1039);
            if (p == 65) chk("fade_pop65", 32'(bus.pwm_sample), 32'd2047);
        end

        // Volume shifts at full gain
        bus.vol = 3'd3;
        period(0);
        chk("vol3_zero", 32'(bus.pwm_sample), 32'd896);
        period(2047);
        chk("vol3_max",  32'(bus.pwm_sample), 32'd1151);
        bus.vol = 3'd7;
        period(0);
        chk("vol7_zero", 32'(bus.pwm_sample), 32'd1016);
        bus.vol = 3'd0;

        // FIFO full, then pop-only with s_valid still high
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 100 + 100 * i, 1'b0);
            step();
            if (i == 3) chk("full_ready_low", 32'(bus.s_ready), 32'd0);
        end
        drive(1'b1, 999, 1'b1);
        step();
        chk("pop_ready_high", 32'(bus.s_ready),    32'd1);
        chk("pop_head",       32'(bus.pwm_sample), 32'd100);
        drive(1'b0, 0, 1'b1);
        repeat (3) step();
        chk("drain_last", 32'(bus.pwm_sample), 32'd400);

        // Underrun: two empty pulses, then an empty pulse with a push
        step();
        chk("und1", 32'(bus.underrun), 32'd1);
        step();
        chk("und2",      32'(bus.underrun),   32'd1);
        chk("und_hold",  32'(bus.pwm_sample), 32'd400);
        drive(1'b1, 300, 1'b1);
        step();
        chk("und3",      32'(bus.underrun),   32'd1);
        chk("und3_hold", 32'(bus.pwm_sample), 32'd400);
        drive(1'b0, 0, 1'b0);
        step();
        chk("und_clear", 32'(bus.underrun), 32'd0);
        drive(1'b0, 0, 1'b1);
        step();
        chk("und_stored", 32'(bus.pwm_sample), 32'd300);
        drive(1'b0, 0, 1'b0);

        // Mute decay, ramp back up, reversal at g=32
        bus.mute = 1'b1;
        for (int p = 0; p < 65; p++) period(2047);
        chk("mute_out",   32'(bus.pwm_sample), 32'd1024);
        chk("mute_flag",  32'(bus.muted),      32'd1);
        bus.mute = 1'b0;
        for (int p = 0; p < 64; p++) period(2047);
        bus.mute = 1'b1;
        for (int p = 0; p < 32; p++) period(2047);
        bus.mute = 1'b0;
        period(2047);
        chk("rev_g32", 32'(bus.pwm_sample), 32'd1535);
        period(2047);
        chk("rev_g33", 32'(bus.pwm_sample), 32'd1551);

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 1600; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)),
                  ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 15) == 0) bus.vol = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) bus.mute = ~bus.mute;
            step();
            if (i == 800) begin
                #3;
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("mid_rst_pwm",      32'(bus.pwm_sample), 32'd1024);
                chk("mid_rst_muted",    32'(bus.muted),      32'd1);
                chk("mid_rst_ready",    32'(bus.s_ready),    32'd1);
                chk("mid_rst_underrun", 32'(bus.underrun),   32'd0);
                step();
                rst_n = 1'b1;
                drive(1'b0, 0, 1'b1);
                step();
                chk("mid_rst_flushed", 32'(bus.underrun), 32'd1);
            end
        end
        drive(1'b0, 0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
